bird_game_ctrl: RTL and testbench
=================================

Name: bird_game_ctrl

Overview:
Game sequencer for the single-column bird display. Owns the game state (idle/play/lose) and turns a raw flap key into one-cycle flap pulses. Generates periodic gravity pulses. Detects collisions of the bird position with the pipe column and the ground, then drives the lose input of the bird movement block. Keeps a score of pipes cleared.

Parameters:
GRAV_DIV, 8, clock cycles between gravity pulses in PLAY (>=2)
SCORE_W, 4, width of score counter
POS_W, 8, width of bird position / pipe mask (one bit per light, bit 0 = ground)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (reset==0 resets on the clk rising edge)
key_flap  in  1  flap key level, already synchronized to clk
start  in  1  start/acknowledge key level, already synchronized
position  in  POS_W  one-hot bird position from movement block
pipe_at_bird  in  1  high while a pipe occupies the bird's column
pipe_mask  in  POS_W  lights blocked by the pipe (1 = wall), valid when pipe_at_bird
flap  out  1  one-cycle pulse to movement block press/L
gravity  out  1  one-cycle pulse to movement block gravity/R
lose  out  1  level, high in LOSE state
playing  out  1  level, high in PLAY state
score  out  SCORE_W  pipes cleared this game, saturating

Behaviour:
- Reset (reset==0): state=IDLE, flap=0, gravity=0, lose=0, playing=0, score=0, gravity counter=0, edge-detect history=0.
- All outputs registered; flap/gravity appear the cycle after their cause.
- Edge detection: key_flap and start use rising edges; pipe_at_bird uses its falling edge. A held key produces exactly one pulse.
- IDLE: no pulses. A start rise goes to PLAY, clears score and the counter.
- PLAY, flap: a key_flap rise gives flap=1 for 1 cycle and restarts the gravity counter at 0. No gravity pulse occurs in that cycle; flap wins any tie.
- PLAY, gravity: the counter increments each cycle. At GRAV_DIV-1 it asserts gravity=1 for 1 cycle and wraps to 0.
- PLAY, collision: collision = pipe_at_bird && |(position & pipe_mask). Ground = position[0] && a gravity pulse is issued in the same cycle.
  - Either condition moves the block to LOSE next cycle.
  - Collision has priority over scoring in the same cycle.
- PLAY, score: a pipe_at_bird fall with no collision that cycle increments score. Score saturates at 2^SCORE_W-1.
- LOSE: lose=1, no flap/gravity pulses, score frozen. A start rise moves to IDLE with lose=0 and score kept until the next game starts.
- A start rise during PLAY is ignored.
- Reset mid-game returns to IDLE with all outputs cleared on that edge.
- position is not checked for one-hot; an all-zero position never collides.

Optional Feature:
SPEEDUP_EN
- Defined: the effective gravity period is max(2, GRAV_DIV - score/4), recomputed when score changes. A counter already >= the new period-1 fires on the next cycle.
- Undefined: the period is fixed at GRAV_DIV.

Decomposition:
- Package bird_pkg:
  - game_state_t enum {IDLE, PLAY, LOSE}.
  - GRAV_MIN=2 and SPEEDUP_STEP=4 constants.
  - Shared POS_W default.
- Sub-module edge_pulse: a registered level input that outputs rise and fall pulses. It is instantiated for key_flap, start and pipe_at_bird.

Test Plan:
- Reset low 2 cycles, then start rise → playing=1; with no flap and GRAV_DIV=8, gravity pulses every 8 cycles exactly.
- In PLAY, hold key_flap high 5 cycles → exactly one flap pulse; the next gravity pulse comes 8 cycles after the flap.
- position=8'b0000_0001 and counter reaches 7 → gravity=1, then lose=1 and playing=0 next cycle; later key_flap rises produce no flap.
- pipe_at_bird=1, pipe_mask=8'b1100_0011, position=8'b0001_0000, then pipe_at_bird falls → score 0→1. Repeat with position=8'b0000_0010 → LOSE, score stays 1.
- 16 clean pipe passes with SCORE_W=4 → score saturates at 15.
- reset low during PLAY with score=3 → next cycle IDLE, score=0, all outputs 0. With SPEEDUP_EN and score=8, gravity period = 6.

Source files
------------

// File: rtl/bird_pkg.sv
// -----------------------------------------------------------------------------
// bird_pkg
// Shared types and constants for the bird game sequencer.
//   game_state_t : IDLE / PLAY / LOSE
//   GRAV_MIN     : shortest allowed gravity period (cycles)
//   SPEEDUP_STEP : pipes cleared per one-cycle shortening of the gravity period
//   POS_W_DEF    : default width of bird position / pipe mask
//   grav_period(): gravity period for a given score when SPEEDUP_EN is built in
// -----------------------------------------------------------------------------
package bird_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        LOSE = 2'd2
    } game_state_t;

    localparam int GRAV_MIN     = 2;
    localparam int SPEEDUP_STEP = 4;
    localparam int POS_W_DEF    = 8;

    // Gravity period shrinks by one cycle for every SPEEDUP_STEP pipes,
    // never going below GRAV_MIN.
    function automatic int grav_period(input int grav_div, input int score_val);
        int p;
        p = grav_div - (score_val / SPEEDUP_STEP);
        if (p < GRAV_MIN) begin
            p = GRAV_MIN;
        end
        return p;
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// -----------------------------------------------------------------------------
// edge_pulse
// Keeps a one-cycle history of a synchronized level and reports its edges.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous active-low reset (clears the history to 0)
//   i_level  in  synchronized level input
//   o_rise   out high in the cycle i_level is first seen high
//   o_fall   out high in the cycle i_level is first seen low
// -----------------------------------------------------------------------------
module edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic i_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_rise = i_level & ~r_prev;
    assign o_fall = ~i_level & r_prev;

endmodule

// File: rtl/bird_game_ctrl.sv
// -----------------------------------------------------------------------------
// bird_game_ctrl
// Game sequencer for the single-column bird display: owns IDLE/PLAY/LOSE,
// turns the flap key into one-cycle flap pulses, issues periodic gravity
// pulses, detects pipe/ground collisions and counts pipes cleared.
// Optional build macro: SPEEDUP_EN (gravity period shortens as score grows).
// Ports:
//   clk           in  system clock
//   reset         in  synchronous active-low reset
//   key_flap      in  flap key level (synchronized)
//   start         in  start/acknowledge key level (synchronized)
//   position      in  [POS_W] one-hot bird position, bit 0 = ground
//   pipe_at_bird  in  high while a pipe occupies the bird's column
//   pipe_mask     in  [POS_W] lights blocked by the pipe (1 = wall)
//   flap          out one-cycle pulse to the movement block
//   gravity       out one-cycle pulse to the movement block
//   lose          out high in LOSE
//   playing       out high in PLAY
//   score         out [SCORE_W] pipes cleared this game, saturating
// Handshake: none; all inputs are levels, flap/gravity are single-cycle
// strobes registered one cycle after their cause.
// -----------------------------------------------------------------------------
module bird_game_ctrl
    import bird_pkg::*;
#(
    parameter int GRAV_DIV = 8,
    parameter int SCORE_W  = 4,
    parameter int POS_W    = POS_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_flap,
    input  logic               start,
    input  logic [POS_W-1:0]   position,
    input  logic               pipe_at_bird,
    input  logic [POS_W-1:0]   pipe_mask,
    output logic               flap,
    output logic               gravity,
    output logic               lose,
    output logic               playing,
    output logic [SCORE_W-1:0] score
);

    localparam int CNT_W = $clog2(GRAV_DIV);

    game_state_t        r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_flap;
    logic               r_grav;
    logic [SCORE_W-1:0] r_score;

    game_state_t        w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_flap_nxt;
    logic               w_grav_nxt;
    logic [SCORE_W-1:0] w_score_nxt;

    logic w_key_rise, w_key_fall;
    logic w_start_rise, w_start_fall;
    logic w_pipe_rise, w_pipe_fall;
    logic w_unused_edges;
    logic w_collide;
    logic w_ground;
    logic w_grav_due;
    int   w_period;

    edge_pulse u_key_edge (
        .clk     (clk),
        .reset   (reset),
        .i_level (key_flap),
        .o_rise  (w_key_rise),
        .o_fall  (w_key_fall)
    );

    edge_pulse u_start_edge (
        .clk     (clk),
        .reset   (reset),
        .i_level (start),
        .o_rise  (w_start_rise),
        .o_fall  (w_start_fall)
    );

    edge_pulse u_pipe_edge (
        .clk     (clk),
        .reset   (reset),
        .i_level (pipe_at_bird),
        .o_rise  (w_pipe_rise),
        .o_fall  (w_pipe_fall)
    );

    // Only the key/start rises and the pipe fall drive the game.
    assign w_unused_edges = ^{w_key_fall, w_start_fall, w_pipe_rise};

    always_comb begin
`ifdef SPEEDUP_EN
        w_period = grav_period(GRAV_DIV, int'(r_score));
`else
        w_period = GRAV_DIV;
`endif
    end

    // ">=" rather than "==" so a period that just shrank below the current
    // count fires on the next cycle instead of running all the way around.
    assign w_grav_due = (int'(r_cnt) >= (w_period - 1));

    // An all-zero position never overlaps the mask, so it never collides.
    assign w_collide = pipe_at_bird && (|(position & pipe_mask));
    // Ground hit: bird sits on bit 0 while the gravity pulse is being applied.
    assign w_ground  = position[0] && r_grav;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_flap  <= 1'b0;
            r_grav  <= 1'b0;
            r_score <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_flap  <= w_flap_nxt;
            r_grav  <= w_grav_nxt;
            r_score <= w_score_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_flap_nxt  = 1'b0;
        w_grav_nxt  = 1'b0;
        w_score_nxt = r_score;

        case (r_state)
            IDLE: begin
                if (w_start_rise) begin
                    w_state_nxt = PLAY;
                    w_cnt_nxt   = '0;
                    w_score_nxt = '0;
                end
            end

            PLAY: begin
                // A hit ends the game before any pulse or score update.
                if (w_collide || w_ground) begin
                    w_state_nxt = LOSE;
                end else begin
                    if (w_key_rise) begin
                        w_flap_nxt = 1'b1;
                        w_cnt_nxt  = '0;
                    end else if (w_grav_due) begin
                        w_grav_nxt = 1'b1;
                        w_cnt_nxt  = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end

                    if (w_pipe_fall && (r_score != {SCORE_W{1'b1}})) begin
                        w_score_nxt = r_score + 1'b1;
                    end
                end
            end

            LOSE: begin
                if (w_start_rise) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign flap    = r_flap;
    assign gravity = r_grav;
    assign lose    = (r_state == LOSE);
    assign playing = (r_state == PLAY);
    assign score   = r_score;

endmodule

// File: tb/tb_bird_game_ctrl.sv
module tb_bird_game_ctrl;

  localparam int GRAV_DIV = 8;
  localparam int SCORE_W  = 4;
  localparam int POS_W    = 8;
  localparam int EXP_W    = 4 + SCORE_W;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  // ---------------- clock / reset / signals ----------------
  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               key_flap = 1'b0;
  logic               start = 1'b0;
  logic [POS_W-1:0]   position = '0;
  logic               pipe_at_bird = 1'b0;
  logic [POS_W-1:0]   pipe_mask = '0;
  logic               flap;
  logic               gravity;
  logic               lose;
  logic               playing;
  logic [SCORE_W-1:0] score;

  always #5 clk = ~clk;

  bird_game_ctrl #(
    .GRAV_DIV (GRAV_DIV),
    .SCORE_W  (SCORE_W),
    .POS_W    (POS_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_flap     (key_flap),
    .start        (start),
    .position     (position),
    .pipe_at_bird (pipe_at_bird),
    .pipe_mask    (pipe_mask),
    .flap         (flap),
    .gravity      (gravity),
    .lose         (lose),
    .playing      (playing),
    .score        (score)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Game described as: mode (0 idle, 1 play, 2 lose), cycles since the last
  // gravity/flap event, score, and the previous input levels for edges.
  int m_mode  = 0;
  int m_age   = 0;
  int m_score = 0;
  bit e_flap  = 0;
  bit e_grav  = 0;
  bit p_key   = 0;
  bit p_start = 0;
  bit p_pipe  = 0;

  function automatic int period_for(input int sc);
`ifdef SPEEDUP_EN
    int p;
    p = GRAV_DIV - sc / 4;
    return (p < 2) ? 2 : p;
`else
    return GRAV_DIV + 0 * sc;
`endif
  endfunction

  // Predict what the outputs will be after the coming clock edge.
  task automatic model_step();
    bit key_up, start_up, pipe_gone, hit, on_ground;
    key_up    = key_flap && !p_key;
    start_up  = start && !p_start;
    pipe_gone = !pipe_at_bird && p_pipe;
    if (!reset) begin
      m_mode = 0; m_age = 0; m_score = 0; e_flap = 0; e_grav = 0;
      p_key = 0; p_start = 0; p_pipe = 0;
    end else begin
      hit       = pipe_at_bird && ((position & pipe_mask) != 0);
      on_ground = position[0] && e_grav;
      e_flap = 0;
      e_grav = 0;
      if (m_mode == 0) begin
        if (start_up) begin
          m_mode = 1; m_age = 0; m_score = 0;
        end
      end else if (m_mode == 1) begin
        if (hit || on_ground) begin
          m_mode = 2;
        end else begin
          if (key_up) begin
            e_flap = 1; m_age = 0;
          end else if (m_age + 1 >= period_for(m_score)) begin
            e_grav = 1; m_age = 0;
          end else begin
            m_age++;
          end
          if (pipe_gone && m_score < SCORE_MAX) m_score++;
        end
      end else begin
        if (start_up) m_mode = 0;
      end
      p_key = key_flap; p_start = start; p_pipe = pipe_at_bird;
    end
    exp_q.push_back({e_flap, e_grav, (m_mode == 2), (m_mode == 1), SCORE_W'(m_score)});
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    logic [EXP_W-1:0] e;
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("flap",    {31'd0, flap},    {31'd0, e[EXP_W-1]});
    chk("gravity", {31'd0, gravity}, {31'd0, e[EXP_W-2]});
    chk("lose",    {31'd0, lose},    {31'd0, e[EXP_W-3]});
    chk("playing", {31'd0, playing}, {31'd0, e[EXP_W-4]});
    chk("score",   32'(score),       32'(e[SCORE_W-1:0]));
  endtask

  task automatic new_game();
    reset = 1'b0; start = 1'b0; key_flap = 1'b0; pipe_at_bird = 1'b0;
    tick();
    reset = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic pipe_pass();
    pipe_at_bird = 1'b1;
    tick();
    pipe_at_bird = 1'b0;
    tick();
  endtask

  // Cycles between two consecutive gravity pulses; -1 if none appear in time.
  task automatic measure_gap(output int gap);
    int k;
    gap = -1;
    for (k = 0; k < 40 && !gravity; k++) tick();
    if (gravity) begin
      for (int j = 1; j <= 40; j++) begin
        tick();
        if (gravity) begin
          gap = j;
          break;
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int gap, nflap, since, k;

    // Reset held for two cycles.
    reset = 1'b0;
    tick();
    tick();
    chk("rst_outputs", {28'd0, flap, gravity, lose, playing}, 32'd0);
    chk("rst_score", 32'(score), 32'd0);

    // Start rise -> PLAY, gravity every GRAV_DIV cycles.
    reset = 1'b1;
    position = 8'b0001_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_play", {31'd0, playing}, 32'd1);
    measure_gap(gap);
    chk("grav_period", gap, 32'd8);

    // Held flap key -> one pulse, next gravity 8 cycles after the flap.
    nflap = 0; since = -1; gap = -1;
    for (int i = 0; i < 30; i++) begin
      key_flap = (i < 5);
      tick();
      if (flap) begin
        nflap++; since = 0;
      end else if (since >= 0) begin
        since++;
        if (gravity && gap < 0) gap = since;
      end
    end
    chk("flap_once", nflap, 32'd1);
    chk("flap_to_grav", gap, 32'd8);

    // Clean pass scores, collision loses and freezes score.
    new_game();
    position = 8'b0001_0000;
    pipe_mask = 8'b1100_0011;
    pipe_at_bird = 1'b1;
    tick(); tick(); tick();
    pipe_at_bird = 1'b0;
    tick();
    chk("score_pass", 32'(score), 32'd1);
    position = 8'b0000_0010;
    pipe_at_bird = 1'b1;
    tick();
    chk("collide_lose", {31'd0, lose}, 32'd1);
    tick();
    chk("collide_score", 32'(score), 32'd1);
    pipe_at_bird = 1'b0;

    // Ground hit on a gravity pulse, then flaps are ignored in LOSE.
    new_game();
    position = 8'b0000_0001;
    for (k = 0; k < 20 && !gravity; k++) tick();
    chk("ground_grav_seen", {31'd0, gravity}, 32'd1);
    tick();
    chk("ground_lose", {30'd0, lose, playing}, 32'd2);
    key_flap = 1'b0;
    tick();
    key_flap = 1'b1;
    tick();
    chk("lose_no_flap", {31'd0, flap}, 32'd0);
    key_flap = 1'b0;
    // Start acknowledges LOSE, score stays until next game.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ack_idle", {30'd0, lose, playing}, 32'd0);

    // Saturation after 16 passes.
    new_game();
    position = 8'b0001_0000;
    for (int i = 0; i < 16; i++) pipe_pass();
    chk("score_sat", 32'(score), 32'd15);

    // Reset in the middle of a game with score 3.
    new_game();
    for (int i = 0; i < 3; i++) pipe_pass();
    chk("score_three", 32'(score), 32'd3);
    reset = 1'b0;
    tick();
    chk("midrst_outputs", {28'd0, flap, gravity, lose, playing}, 32'd0);
    chk("midrst_score", 32'(score), 32'd0);
    reset = 1'b1;

    // Gravity period at score 8.
    new_game();
    for (int i = 0; i < 8; i++) pipe_pass();
    measure_gap(gap);
`ifdef SPEEDUP_EN
    chk("grav_period_s8", gap, 32'd6);
`else
    chk("grav_period_s8", gap, 32'd8);
`endif

    // Randomized play checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 3) == 0) key_flap = ~key_flap;
      if ($urandom_range(0, 9) == 0) start = ~start;
      if ($urandom_range(0, 5) == 0) begin
        pipe_at_bird = ~pipe_at_bird;
        pipe_mask = POS_W'($urandom_range(0, 255)) & POS_W'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 15))
          0:       position = '0;
          1, 2:    position = 8'b0000_0001;
          default: position = 8'b0000_0001 << $urandom_range(1, POS_W - 1);
        endcase
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
